score_keeper: RTL and testbench



---
 rtl/score_keeper.sv | 164 ++++++++++++++++
 tb/tb_score_keeper.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper
//   Game-side score accumulator that drives the 8-bit score input of the
//   3-digit score display. Awards are scaled by a streak (combo)
//   multiplier, penalties are subtracted, and the score is clamped to
//   0..MAX_SCORE. A three-state game FSM (IDLE/PLAY/OVER) gates event
//   acceptance. A high-score register is updated on game over.
//
// Ports
//   clk         in   system clock, all state on rising edge
//   reset       in   asynchronous active-high reset
//   start       in   begin a new game (from IDLE or OVER)
//   game_over   in   end the current game (wins over start in PLAY)
//   add_valid   in   award event
//   add_pts     in   [3:0] base award points
//   sub_valid   in   penalty event
//   sub_pts     in   [3:0] penalty points
//   score       out  [7:0] current score
//   high_score  out  [7:0] best score since reset
//   combo       out  [1:0] streak level 0..3
//   playing     out  high while in PLAY
//   new_high    out  one-cycle pulse after high_score is raised
//
// Event handshake: add_valid/sub_valid are single-cycle qualifiers with no
// back-pressure. An event is consumed on the rising edge where it is high,
// the FSM is in PLAY and game_over is low; otherwise it is dropped.

module score_keeper #(
  parameter int MAX_SCORE    = 255,
  parameter int COMBO_WINDOW = 25000000,
  parameter int TIMER_W      = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       game_over,
  input  logic       add_valid,
  input  logic [3:0] add_pts,
  input  logic       sub_valid,
  input  logic [3:0] sub_pts,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [1:0] combo,
  output logic       playing,
  output logic       new_high
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  // Timer value meaning "no award inside the window"; it is also the
  // saturation point of the gap timer.
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(COMBO_WINDOW + 1);
  localparam logic [TIMER_W-1:0] WINDOW    = TIMER_W'(COMBO_WINDOW);
  localparam logic signed [9:0]  MAX_S     = 10'(MAX_SCORE);

  state_t             state_q, state_d;
  logic [7:0]         score_q, score_d;
  logic [7:0]         high_q, high_d;
  logic [1:0]         combo_q, combo_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               new_high_q, new_high_d;

  logic               add_acc;
  logic               sub_acc;
  logic [1:0]         combo_next;
  logic [5:0]         add_eff;
  logic [3:0]         sub_eff;
  logic signed [9:0]  sum;

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    combo_d    = combo_q;
    timer_d    = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
    new_high_d = 1'b0;
    add_acc    = 1'b0;
    sub_acc    = 1'b0;

    // Streak level an award in this cycle would be scored at.
    if (timer_q <= WINDOW) begin
      combo_next = (combo_q == 2'd3) ? 2'd3 : combo_q + 2'd1;
    end else begin
      combo_next = 2'd0;
    end

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_PLAY;
          score_d = 8'd0;
          combo_d = 2'd0;
          timer_d = TIMER_MAX;
        end
      end
      ST_PLAY: begin
        if (game_over) begin
          state_d = ST_OVER;
          if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
          end
        end else begin
          add_acc = add_valid;
          sub_acc = sub_valid;
          if (add_acc) begin
            timer_d = TIMER_W'(1);
            combo_d = combo_next;
          end else if (sub_acc) begin
            timer_d = TIMER_MAX;
            combo_d = 2'd0;
          end else if (timer_d == TIMER_MAX) begin
            combo_d = 2'd0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    add_eff = add_acc ? 6'(add_pts) * 6'({1'b0, combo_next} + 3'd1) : 6'd0;
    sub_eff = sub_acc ? sub_pts : 4'd0;

    // 10-bit signed covers -15..255+60 without wrap.
    sum = $signed({2'b00, score_q}) + $signed({4'b0000, add_eff})
        - $signed({6'b000000, sub_eff});
    if (add_acc || sub_acc) begin
      if (sum < 10'sd0) begin
        score_d = 8'd0;
      end else if (sum > MAX_S) begin
        score_d = 8'(MAX_SCORE);
      end else begin
        score_d = sum[7:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      score_q    <= 8'd0;
      high_q     <= 8'd0;
      combo_q    <= 2'd0;
      timer_q    <= TIMER_MAX;
      new_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      combo_q    <= combo_d;
      timer_q    <= timer_d;
      new_high_q <= new_high_d;
    end
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign combo      = combo_q;
  assign playing    = (state_q == ST_PLAY);
  assign new_high   = new_high_q;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  logic       clk;
  logic       reset;
  logic       start;
  logic       game_over;
  logic       add_valid;
  logic [3:0] add_pts;
  logic       sub_valid;
  logic [3:0] sub_pts;
  logic [7:0] score;
  logic [7:0] high_score;
  logic [1:0] combo;
  logic       playing;
  logic       new_high;

  int n_checks;
  int n_pass;

  score_keeper #(
    .MAX_SCORE    (255),
    .COMBO_WINDOW (4),
    .TIMER_W      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .game_over  (game_over),
    .add_valid  (add_valid),
    .add_pts    (add_pts),
    .sub_valid  (sub_valid),
    .sub_pts    (sub_pts),
    .score      (score),
    .high_score (high_score),
    .combo      (combo),
    .playing    (playing),
    .new_high   (new_high)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drivers: inputs change 1 time unit after the rising edge, outputs are
  // sampled at the same point so they reflect the previous edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ev(input logic av, input logic [3:0] ap,
                    input logic sv, input logic [3:0] sp);
    add_valid = av;
    add_pts   = ap;
    sub_valid = sv;
    sub_pts   = sp;
    tick();
    add_valid = 1'b0;
    add_pts   = 4'd0;
    sub_valid = 1'b0;
    sub_pts   = 4'd0;
  endtask

  task automatic add(input logic [3:0] p);
    ev(1'b1, p, 1'b0, 4'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_game_over();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
  endtask

  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulse_start();
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    game_over = 1'b0;
    add_valid = 1'b0;
    add_pts   = 4'd0;
    sub_valid = 1'b0;
    sub_pts   = 4'd0;
    idle(2);
    reset = 1'b0;

    // reset state
    check("rst_score", score, 0);
    check("rst_high", high_score, 0);
    check("rst_combo", combo, 0);
    check("rst_playing", playing, 0);
    check("rst_new_high", new_high, 0);

    // events in IDLE are dropped
    add(4'd9);
    check("idle_add_ignored", score, 0);

    // basic award
    pulse_start();
    check("start_playing", playing, 1);
    check("start_score", score, 0);
    add(4'd5);
    check("basic_score", score, 5);
    check("basic_combo", combo, 0);
    check("basic_playing", playing, 1);

    // streak of 3-point adds with one idle cycle between them
    restart();
    add(4'd3);
    check("streak0_score", score, 3);
    check("streak0_combo", combo, 0);
    idle(1); add(4'd3);
    check("streak1_score", score, 9);
    check("streak1_combo", combo, 1);
    idle(1); add(4'd3);
    check("streak2_score", score, 18);
    check("streak2_combo", combo, 2);
    idle(1); add(4'd3);
    check("streak3_score", score, 30);
    check("streak3_combo", combo, 3);
    idle(1); add(4'd3);
    check("streak4_score", score, 42);
    check("streak4_combo", combo, 3);

    // game over at 42 with high_score 0
    pulse_game_over();
    check("go_playing", playing, 0);
    check("go_high", high_score, 42);
    check("go_new_high", new_high, 1);
    check("go_score_held", score, 42);
    tick();
    check("go_new_high_once", new_high, 0);
    add(4'd5);
    check("over_add_ignored", score, 42);

    // second game reaches 20 and does not beat 42
    pulse_start();
    check("restart_score", score, 0);
    add(4'd15);
    idle(5);
    add(4'd5);
    check("game2_score", score, 20);
    check("game2_combo", combo, 0);
    pulse_game_over();
    check("game2_high_kept", high_score, 42);
    check("game2_no_pulse", new_high, 0);
    tick();
    check("game2_no_pulse_late", new_high, 0);

    // window edge: gap 4 extends the streak, gap 5 breaks it
    restart();
    add(4'd1);
    check("win_first", score, 1);
    idle(3); add(4'd1);
    check("win_gap4_combo", combo, 1);
    check("win_gap4_score", score, 3);
    idle(4); add(4'd1);
    check("win_gap5_combo", combo, 0);
    check("win_gap5_score", score, 4);
    add(4'd1);
    check("win_gap1_combo", combo, 1);
    check("win_gap1_score", score, 6);
    idle(3);
    check("decay_t4_combo", combo, 1);
    idle(1);
    check("decay_t5_combo", combo, 0);

    // ceiling clamp: 16*15 + 10 = 250, then +15 saturates
    restart();
    for (int i = 0; i < 16; i++) begin
      add(4'd15);
      idle(5);
    end
    add(4'd10);
    check("clamp_pre", score, 250);
    idle(5);
    add(4'd15);
    check("clamp_max", score, 255);
    check("clamp_combo", combo, 0);

    // floor clamp with streak cleared by the penalty
    restart();
    add(4'd5);
    add(4'd0);
    check("floor_combo_pre", combo, 1);
    check("floor_score_pre", score, 5);
    ev(1'b0, 4'd0, 1'b1, 4'd7);
    check("floor_score", score, 0);
    check("floor_combo", combo, 0);

    // add and sub in the same cycle
    restart();
    add(4'd10);
    idle(5);
    ev(1'b1, 4'd4, 1'b1, 4'd6);
    check("both_score", score, 8);
    check("both_combo", combo, 0);

    // start together with game_over in PLAY ends the game
    restart();
    add(4'd15);
    start     = 1'b1;
    game_over = 1'b1;
    tick();
    start     = 1'b0;
    game_over = 1'b0;
    check("prio_playing", playing, 0);
    check("prio_high", high_score, 15);
    check("prio_new_high", new_high, 1);

    // asynchronous reset in the middle of a game at score 30
    pulse_start();
    add(4'd15);
    idle(5);
    add(4'd15);
    check("mid_score_pre", score, 30);
    check("mid_playing_pre", playing, 1);
    reset = 1'b1;
    #1;
    check("async_score", score, 0);
    check("async_high", high_score, 0);
    check("async_combo", combo, 0);
    check("async_playing", playing, 0);
    check("async_new_high", new_high, 0);
    tick();
    reset = 1'b0;
    add(4'd7);
    check("post_reset_idle", score, 0);
    check("post_reset_not_playing", playing, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
